bus_arbiter_rr: RTL and testbench

Parametrised N-master bus arbiter for DMA masters sharing the system bus. It supports fixed-priority or round-robin arbitration, selected at run time. An owner may hold the bus for a bounded burst of transfers. A watchdog forcibly reclaims the bus from a stalled slave. It sits between the DMA request lines and the shared bus, and drives grant/req toward masters and slaves.

---
 rtl/bus_arbiter_rr.sv | 158 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_rr
// Description : N-master bus arbiter for DMA masters sharing the system bus.
//               Fixed-priority or round-robin arbitration (run-time select),
//               bounded burst ownership and a watchdog that reclaims the bus
//               from a stalled slave.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               dma_i      - per-master request, level, active-high
//               ready_i    - slave transfer-complete strobe (used while BUSY)
//               rr_mode_i  - 0 = fixed priority, 1 = round robin
//               grant_o    - one-hot (or zero) grant vector
//               req_o      - bus in use (OR of grant)
//               owner_o    - index of granted master, 0 when no grant
//               timeout_o  - one-cycle pulse after a watchdog release
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_rr #(
  parameter int N_MASTERS = 8,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_MASTERS-1:0]         dma_i,
  input  logic                         ready_i,
  input  logic                         rr_mode_i,
  output logic [N_MASTERS-1:0]         grant_o,
  output logic                         req_o,
  output logic [$clog2(N_MASTERS)-1:0] owner_o,
  output logic                         timeout_o
);

  localparam int IDX_W  = $clog2(N_MASTERS);
  localparam int SCAN_W = IDX_W + 1;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [SCAN_W-1:0] C_N_MASTERS = SCAN_W'(N_MASTERS);
  localparam logic [IDX_W-1:0]  C_LAST_IDX  = IDX_W'(N_MASTERS - 1);
  localparam logic [BCNT_W-1:0] C_MAX_BURST = BCNT_W'(MAX_BURST);
  localparam logic [WCNT_W-1:0] C_WDOG_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [N_MASTERS-1:0] C_ONE    = N_MASTERS'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                state_q;
  logic [N_MASTERS-1:0]  grant_q;
  logic [IDX_W-1:0]      owner_q;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [BCNT_W-1:0]     burst_q;
  logic [WCNT_W-1:0]     wdog_q;
  logic                  timeout_q;

  logic                  win_valid_d;
  logic [IDX_W-1:0]      win_idx_d;
  logic [N_MASTERS-1:0]  win_onehot_d;
  logic [IDX_W-1:0]      rr_ptr_d;
  logic [SCAN_W-1:0]     scan_d;

  // Winner select: scan N positions starting at the base (rr_ptr in RR mode,
  // 0 in fixed mode); the first set request found wins. The scan index is one
  // bit wider so base+i can be folded back into range with one subtraction.
  always_comb begin
    win_valid_d = 1'b0;
    win_idx_d   = '0;
    scan_d      = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      scan_d = (rr_mode_i ? {1'b0, rr_ptr_q} : {SCAN_W{1'b0}}) + SCAN_W'(i);
      if (scan_d >= C_N_MASTERS) begin
        scan_d = scan_d - C_N_MASTERS;
      end
      if (!win_valid_d && dma_i[scan_d[IDX_W-1:0]]) begin
        win_valid_d = 1'b1;
        win_idx_d   = scan_d[IDX_W-1:0];
      end
    end
  end

  assign win_onehot_d = C_ONE << win_idx_d;

  // Pointer to the master after the current owner, wrapping at N_MASTERS-1.
  assign rr_ptr_d = (owner_q == C_LAST_IDX) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      burst_q   <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_valid_d) begin
            state_q <= S_BUSY;
            grant_q <= win_onehot_d;
            owner_q <= win_idx_d;
            burst_q <= '0;
            wdog_q  <= '0;
          end
        end
        S_BUSY: begin
          if (!dma_i[owner_q]) begin
            // Owner abandoned the bus.
            state_q  <= S_IDLE;
            rr_ptr_q <= rr_ptr_d;
          end else if (ready_i) begin
            // Owner request is known high here, so only the burst limit matters.
            if ((burst_q + 1'b1) < C_MAX_BURST) begin
              burst_q <= burst_q + 1'b1;
              wdog_q  <= '0;
            end else begin
              state_q  <= S_IDLE;
              rr_ptr_q <= rr_ptr_d;
            end
          end else if (wdog_q == C_WDOG_LAST) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= rr_ptr_d;
            timeout_q <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // IDLE grant is combinational so a request is granted in the same cycle.
  // Reset gates the outputs directly because IDLE would otherwise pass the
  // live request vector through while rst_n is held low.
  always_comb begin
    grant_o = '0;
    owner_o = '0;
    if (rst_n) begin
      if (state_q == S_BUSY) begin
        grant_o = grant_q;
        owner_o = owner_q;
      end else if (win_valid_d) begin
        grant_o = win_onehot_d;
        owner_o = win_idx_d;
      end
    end
  end

  assign req_o     = |grant_o;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_rr
// Description : Directed self-checking bench for bus_arbiter_rr (8 masters,
//               burst limit 4, watchdog 16). Expected outputs are queued when
//               a step is driven and popped/compared once outputs settle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_rr;

  localparam int N_MASTERS = 8;
  localparam int MAX_BURST = 4;
  localparam int TIMEOUT   = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] dma;
  logic       ready;
  logic       rr_mode;
  logic [7:0] grant;
  logic       req;
  logic [2:0] owner;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic       r;
    logic [2:0] o;
    logic       t;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_assert;
  int    n_fail;

  bus_arbiter_rr #(
    .N_MASTERS(N_MASTERS),
    .MAX_BURST(MAX_BURST),
    .TIMEOUT  (TIMEOUT)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dma_i    (dma),
    .ready_i  (ready),
    .rr_mode_i(rr_mode),
    .grant_o  (grant),
    .req_o    (req),
    .owner_o  (owner),
    .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] oh(input int k);
    logic [7:0] one;
    one = 8'd1;
    return one << k;
  endfunction

  task automatic check_one();
    exp_t  e;
    exp_t  obs;
    string tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    obs = '{grant, req, owner, timeout};
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed grant=%h req=%b owner=%0d timeout=%b, expected grant=%h req=%b owner=%0d timeout=%b",
             tag, obs.g, obs.r, obs.o, obs.t, e.g, e.r, e.o, e.t);
    end
  endtask

  // Drive one input set, queue its expected outputs, compare after settling.
  task automatic step(input logic [7:0] d, input logic rdy, input logic rr,
                      input logic [7:0] eg, input logic [2:0] eo, input logic et,
                      input string tag);
    dma     = d;
    ready   = rdy;
    rr_mode = rr;
    exp_q.push_back('{eg, |eg, eo, et});
    tag_q.push_back(tag);
    #1 check_one();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    step(8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "reset_assert");
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 100000");
    $fatal(1, "global timeout");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    dma      = 8'h00;
    ready    = 1'b0;
    rr_mode  = 1'b0;

    // Reset state: outputs forced low even with every master requesting.
    #3;
    step(8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "reset_hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;

    // Fixed priority: same-cycle grant, then grant held while BUSY.
    step(8'h0A, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "fix_same_cycle");
    tick(); step(8'h0B, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "fix_busy_hold");
    tick(); step(8'h09, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, "fix_drop_edge");
    tick(); step(8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, "fix_idle_none");

    // Round robin with all masters requesting: owners 0..7 then 0 again,
    // each ownership released by the 4th ready, with one IDLE cycle between.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(8'hFF, 1'b0, 1'b1, oh(k % 8), 3'(k % 8), 1'b0, "rr_idle_grant");
      for (int b = 0; b < MAX_BURST; b++) begin
        tick(); step(8'hFF, 1'b1, 1'b1, oh(k % 8), 3'(k % 8), 1'b0, "rr_busy_hold");
      end
      tick();
    end

    // Burst limit: grant survives three readies (and a gap), released on the 4th.
    do_reset();
    step(8'h08, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0, "burst_grant");
    tick(); step(8'h18, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0, "burst_r1");
    tick(); step(8'h18, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0, "burst_gap");
    tick(); step(8'h18, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0, "burst_r2");
    tick(); step(8'h18, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0, "burst_r3");
    tick(); step(8'h18, 1'b1, 1'b1, 8'h08, 3'd3, 1'b0, "burst_r4");
    tick(); step(8'h18, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0, "burst_next_rr");

    // Watchdog: 16 BUSY cycles without ready, then one-cycle timeout pulse.
    do_reset();
    step(8'h04, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0, "wd_grant");
    for (int c = 0; c < TIMEOUT; c++) begin
      tick(); step(8'h0C, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0, "wd_busy_hold");
    end
    tick(); step(8'h0C, 1'b0, 1'b1, 8'h08, 3'd3, 1'b1, "wd_release_pulse");
    tick(); step(8'h0C, 1'b0, 1'b1, 8'h08, 3'd3, 1'b0, "wd_pulse_end");

    // Abandon: owner 5 drops its request, next RR owner is 6, no timeout.
    do_reset();
    step(8'h20, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, "ab_grant");
    tick(); step(8'h60, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, "ab_busy_hold");
    tick(); step(8'h41, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, "ab_drop");
    tick(); step(8'h41, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0, "ab_idle_next");

    // Reset mid-burst: immediate release, and rr_ptr returns to 0.
    tick(); step(8'h41, 1'b1, 1'b1, 8'h40, 3'd6, 1'b0, "rm_busy");
    #1 rst_n = 1'b0;
    step(8'h41, 1'b1, 1'b1, 8'h00, 3'd0, 1'b0, "rm_async_clear");
    @(posedge clk);
    #1 step(8'h41, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, "rm_held");
    rst_n = 1'b1;
    step(8'h90, 1'b0, 1'b1, 8'h10, 3'd4, 1'b0, "rm_ptr_zero");
    step(8'h80, 1'b0, 1'b1, 8'h80, 3'd7, 1'b0, "rm_owner7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
